l_outport_sched: RTL

//  Local-port output scheduler sitting between the local-port round-robin priority processor and the crossbar.

---
 rtl/noc_pkg.sv | 46 ++++
 rtl/noc_credit_counter.sv | 38 +++
 rtl/l_outport_sched.sv | 112 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, crossbar select encodings and
// scheduler state type used by all output-port schedulers.
package noc_pkg;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_W = 3'd2,
    PORT_E = 3'd3,
    PORT_L = 3'd4
  } port_idx_t;

  localparam logic [2:0] CS_N    = 3'b000;
  localparam logic [2:0] CS_S    = 3'b001;
  localparam logic [2:0] CS_W    = 3'b010;
  localparam logic [2:0] CS_E    = 3'b011;
  localparam logic [2:0] CS_NONE = 3'b111;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

  // Request/grant vectors are ordered {n,s,w,e} = [3:0], so port index i lives in bit 3-i.
  function automatic logic [1:0] port_bit(input logic [1:0] idx);
    return 2'd3 - idx;
  endfunction

  // Highest set bit wins (N > S > W > E); returns a 2-bit port index.
  function automatic logic [1:0] pick_port(input logic [3:0] grant);
    if (grant[3])      return 2'd0;
    else if (grant[2]) return 2'd1;
    else if (grant[1]) return 2'd2;
    else               return 2'd3;
  endfunction

  function automatic logic [2:0] idx_to_cs(input logic [1:0] idx);
    case (idx)
      2'd0:    return CS_N;
      2'd1:    return CS_S;
      2'd2:    return CS_W;
      default: return CS_E;
    endcase
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream credit counter shared by the output-port schedulers.
// Saturates at MAX on an unmatched return and flags it as overflow.
module noc_credit_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         nonzero,
  output logic         overflow
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign overflow = inc && !dec && (cnt_q == W'(MAX));
  assign nonzero  = (cnt_q != '0);
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (dec && !inc)
      cnt_d = cnt_q - W'(1);
    else if (inc && !dec && !overflow)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= W'(MAX);
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/l_outport_sched.sv
// Local output-port scheduler: locks the local output to one input for a whole
// packet, drives the crossbar select, and tracks downstream credits.
module l_outport_sched
  import noc_pkg::*;
#(
  parameter int unsigned CREDITS_MAX = 4,
  parameter int unsigned CNT_W       = $clog2(CREDITS_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       rrp_grant_i,
  input  logic [3:0]       flit_valid_i,
  input  logic [3:0]       flit_tail_i,
  input  logic             credit_return_i,
  output logic [2:0]       cs_sel_o,
  output logic [3:0]       pop_o,
  output logic             out_valid_o,
  output logic             rr_change_order_o,
  output logic             rr_downstream_credit_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] credit_cnt_o,
  output logic             err_o
);

  sched_state_t state_q, state_d;
  logic [1:0]   owner_q, owner_d;
  logic [1:0]   cand;
  logic [1:0]   sel_idx;
  logic         sel_vld;
  logic         send;
  logic         tail_sent;
  logic         multi_hot;
  logic         credit_nz;
  logic         credit_ovf;
  logic         chg_q;
  logic         err_q;

  noc_credit_counter #(
    .MAX (CREDITS_MAX),
    .W   (CNT_W)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .dec      (send),
    .inc      (credit_return_i),
    .cnt      (credit_cnt_o),
    .nonzero  (credit_nz),
    .overflow (credit_ovf)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    sel_idx   = 2'd0;
    sel_vld   = 1'b0;
    send      = 1'b0;
    tail_sent = 1'b0;
    multi_hot = 1'b0;
    cand      = pick_port(rrp_grant_i);
    case (state_q)
      IDLE: begin
        multi_hot = ((rrp_grant_i & (rrp_grant_i - 4'd1)) != '0);
        sel_idx   = cand;
        send      = (|rrp_grant_i) && flit_valid_i[port_bit(cand)] && credit_nz;
        // In IDLE the select only points at an input when a flit actually moves.
        sel_vld   = send;
        if (send && !flit_tail_i[port_bit(cand)]) begin
          state_d = LOCKED;
          owner_d = cand;
        end
      end
      LOCKED: begin
        sel_idx = owner_q;
        sel_vld = 1'b1;
        send    = flit_valid_i[port_bit(owner_q)] && credit_nz;
        if (send && flit_tail_i[port_bit(owner_q)])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tail_sent = send && flit_tail_i[port_bit(sel_idx)];
    // Combinational outputs are held quiet while reset is asserted.
    if (reset) begin
      send      = 1'b0;
      sel_vld   = 1'b0;
      tail_sent = 1'b0;
    end
  end

  assign cs_sel_o               = sel_vld ? idx_to_cs(sel_idx) : CS_NONE;
  assign pop_o                  = send ? (4'b1000 >> sel_idx) : '0;
  assign out_valid_o            = send;
  assign busy_o                 = (state_q == LOCKED);
  assign rr_downstream_credit_o = credit_nz;
  assign rr_change_order_o      = chg_q;
  assign err_o                  = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      chg_q   <= tail_sent;
      err_q   <= err_q | multi_hot | credit_ovf;
    end
  end

endmodule
